// File: rtl/mux_n_pipe.sv
// Pipelined N:1 word selector (radix-4 tree). Latency 1 edge, or 2 edges with PIPE_MID; one selection per cycle.
// iStall freezes every stage and drops that cycle's input; iFlush kills in-flight entries; reset beats both.
module mux_n_pipe #(
   parameter int               WIDTH     = 32,
   parameter int               N_IN      = 8,
   parameter int               SEL_W     = 3,
   parameter int               PIPE_MID  = 0,
   parameter int               HOLD_LAST = 1,
   parameter logic [WIDTH-1:0] DEFAULT   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iValid,
   input  logic                  iStall,
   input  logic                  iFlush,
   input  logic [N_IN*WIDTH-1:0] iData,
   input  logic [SEL_W-1:0]      iCtrl,
   output logic                  oValid,
   output logic [WIDTH-1:0]      oData,
   output logic                  oSelErr
);

   localparam int NG0 = (N_IN + 3) / 4;
   localparam int NG1 = (NG0 + 3) / 4;

   if (SEL_W != $clog2(N_IN)) begin : g_bad_sel_w
      $error("mux_n_pipe: SEL_W must equal ceil(log2(N_IN))");
   end
   if (N_IN < 2 || N_IN > 64) begin : g_bad_n_in
      $error("mux_n_pipe: N_IN must be in 2..64");
   end
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("mux_n_pipe: WIDTH must be in 1..64");
   end

   // Select widened to three radix-4 levels; upper levels collapse to pass-through for small N_IN.
   logic [5:0] sel_in;
   logic       err_in;

   assign sel_in = 6'(iCtrl);
   assign err_in = (7'(iCtrl) >= 7'(N_IN));

   // Level 0: groups of four input words, missing words read as DEFAULT.
   logic [NG0-1:0][3:0][WIDTH-1:0] cand0;
   logic [NG0-1:0][WIDTH-1:0]      lvl0;

   for (genvar g = 0; g < NG0; g++) begin : g_l0
      for (genvar k = 0; k < 4; k++) begin : g_w
         if (4*g + k < N_IN) begin : g_real
            assign cand0[g][k] = iData[(4*g + k)*WIDTH +: WIDTH];
         end else begin : g_pad
            assign cand0[g][k] = DEFAULT;
         end
      end
      assign lvl0[g] = cand0[g][sel_in[1:0]];
   end

   // Stage feeding the upper levels: either live inputs or the mid-tree registers.
   logic [NG0-1:0][WIDTH-1:0] l1_src;
   logic [3:0]                sel_up;
   logic                      st_vld;
   logic                      st_err;

   if (PIPE_MID != 0) begin : g_mid
      logic [NG0-1:0][WIDTH-1:0] mid_dat_q, mid_dat_d;
      logic [3:0]                mid_sel_q, mid_sel_d;
      logic                      mid_vld_q, mid_vld_d;
      logic                      mid_err_q, mid_err_d;

      always_comb begin
         mid_dat_d = mid_dat_q;
         mid_sel_d = mid_sel_q;
         mid_vld_d = mid_vld_q;
         mid_err_d = mid_err_q;
         if (iFlush) begin
            mid_vld_d = 1'b0;
            mid_err_d = 1'b0;
         end else if (!iStall) begin
            mid_dat_d = lvl0;
            mid_sel_d = sel_in[5:2];
            mid_vld_d = iValid;
            mid_err_d = err_in;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            mid_dat_q <= '0;
            mid_sel_q <= '0;
            mid_vld_q <= 1'b0;
            mid_err_q <= 1'b0;
         end else begin
            mid_dat_q <= mid_dat_d;
            mid_sel_q <= mid_sel_d;
            mid_vld_q <= mid_vld_d;
            mid_err_q <= mid_err_d;
         end
      end

      assign l1_src = mid_dat_q;
      assign sel_up = mid_sel_q;
      assign st_vld = mid_vld_q;
      assign st_err = mid_err_q;
   end else begin : g_nomid
      assign l1_src = lvl0;
      assign sel_up = sel_in[5:2];
      assign st_vld = iValid;
      assign st_err = err_in;
   end

   // Level 1: groups of four level-0 results.
   logic [NG1-1:0][3:0][WIDTH-1:0] cand1;
   logic [NG1-1:0][WIDTH-1:0]      lvl1;

   for (genvar h = 0; h < NG1; h++) begin : g_l1
      for (genvar k = 0; k < 4; k++) begin : g_w
         if (4*h + k < NG0) begin : g_real
            assign cand1[h][k] = l1_src[4*h + k];
         end else begin : g_pad
            assign cand1[h][k] = DEFAULT;
         end
      end
      assign lvl1[h] = cand1[h][sel_up[1:0]];
   end

   // Level 2: at most four level-1 results remain.
   logic [3:0][WIDTH-1:0] cand2;
   logic [WIDTH-1:0]      tree_dat;
   logic [WIDTH-1:0]      st_dat;

   for (genvar k = 0; k < 4; k++) begin : g_l2
      if (k < NG1) begin : g_real
         assign cand2[k] = lvl1[k];
      end else begin : g_pad
         assign cand2[k] = DEFAULT;
      end
   end

   assign tree_dat = cand2[sel_up[3:2]];
   assign st_dat   = st_err ? DEFAULT : tree_dat;

   // Output register.
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             err_q, err_d;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      err_d = err_q;
      if (iFlush) begin
         vld_d = 1'b0;
         err_d = 1'b0;
         if (HOLD_LAST == 0) dat_d = '0;
      end else if (!iStall) begin
         vld_d = st_vld;
         if (st_vld) begin
            dat_d = st_dat;
            err_d = st_err;
         end else begin
            err_d = 1'b0;
            if (HOLD_LAST == 0) dat_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         dat_q <= '0;
         err_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         err_q <= err_d;
      end
   end

   assign oValid  = vld_q;
   assign oData   = dat_q;
   assign oSelErr = err_q;

endmodule
